maxpool_stage: RTL and testbench

- 2x2, stride-2 pooling stage directly downstream of the convolution engine.
- Consumes the 6x6 signed post-ReLU feature map as a raster-order valid/ready stream.
- Emits a 3x3 pooled map, also raster order, on a valid/ready stream.
- Holds one row of partial results, so it never buffers a full frame.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/pool_reduce2.sv | 25 ++
 rtl/maxpool_stage.sv | 160 ++++++++++++++++
 tb/tb_maxpool_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN pipeline constants and pooling state type
// Purpose: default sample width, convolution output feature-map size,
//          the width growth of the pooling reduce operator, and the pooling
//          stage state enum.
// Build option: POOL_AVG_EN selects average pooling (reduce grows by one bit).
package cnn_pkg;

  localparam int DATA_W = 32;
  localparam int FEAT_W = 6;
  localparam int FEAT_H = 6;

`ifdef POOL_AVG_EN
  // A sum of two W-bit signed values needs W+1 bits.
  localparam int REDUCE_GROW = 1;
`else
  // A max of two values is as wide as its inputs.
  localparam int REDUCE_GROW = 0;
`endif

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_reduce2.sv
// rtl/pool_reduce2.sv - combinational two-input signed max or sum
// Purpose: the reduce operator shared by the pair stage and the row-combine
//          stage of the pooling block.
// Build option: POOL_AVG_EN -> signed sum (output W+1 bits);
//               otherwise    -> signed max (output W bits).
// Ports:
//   a, b  in   W                  signed operands
//   y     out  W+REDUCE_GROW      reduced result
module pool_reduce2
  import cnn_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  output logic [W+REDUCE_GROW-1:0] y
);

`ifdef POOL_AVG_EN
  assign y = {a[W-1], a} + {b[W-1], b};
`else
  assign y = ($signed(a) > $signed(b)) ? a : b;
`endif

endmodule

// File: rtl/maxpool_stage.sv
// rtl/maxpool_stage.sv - 2x2 stride-2 pooling stage on a raster valid/ready stream
// Purpose: pools an IN_W x IN_H signed feature map into (IN_W/2) x (IN_H/2)
//          outputs, keeping only one row of horizontal partial results.
// Build option: POOL_AVG_EN selects average pooling; default is max pooling.
// Ports:
//   clk         in   1       clock
//   rst         in   1       asynchronous active-high reset
//   in_valid    in   1       input sample valid
//   in_ready    out  1       stage can accept an input sample
//   in_data     in   DATA_W  signed input sample, raster order
//   out_valid   out  1       pooled sample valid
//   out_ready   in   1       downstream accepts the pooled sample
//   out_data    out  DATA_W  signed pooled sample
//   frame_done  out  1       one-cycle pulse after last pooled sample is taken
module maxpool_stage #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IN_W   = cnn_pkg::FEAT_W,
  parameter int IN_H   = cnn_pkg::FEAT_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  import cnn_pkg::*;

  localparam int PAIR_W = DATA_W + REDUCE_GROW;
  localparam int QUAD_W = PAIR_W + REDUCE_GROW;
  localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int BW     = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;

  pool_state_e       state;
  pool_state_e       state_next;
  logic              done_next;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] h_reg;
  logic [PAIR_W-1:0] row_buf [IN_W/2];

  logic              in_fire;
  logic              out_fire;
  logic              col_last;
  logic              row_last;
  logic              produce;
  logic [BW-1:0]     buf_idx;
  logic [PAIR_W-1:0] pair;
  logic [QUAD_W-1:0] quad;
  logic [DATA_W-1:0] pooled;

  assign in_ready = (state == ACCEPT) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));
  // Odd row, odd column closes a 2x2 window.
  assign produce  = in_fire && row[0] && col[0];
  assign buf_idx  = BW'(col >> 1);

  // Horizontal pair: previous even-column sample with the current one.
  pool_reduce2 #(.W(DATA_W)) u_pair (
    .a (h_reg),
    .b (in_data),
    .y (pair)
  );

  // Vertical combine: the stored upper-row pair with the current lower-row pair.
  pool_reduce2 #(.W(PAIR_W)) u_row (
    .a (row_buf[buf_idx]),
    .b (pair),
    .y (quad)
  );

`ifdef POOL_AVG_EN
  // Taking bits [DATA_W+1:2] is an arithmetic shift right by 2 (floor)
  // followed by truncation to DATA_W.
  logic [1:0] quad_unused;
  assign quad_unused = quad[1:0];
  assign pooled      = quad[DATA_W+1:2];
`else
  assign pooled = quad;
`endif

  // Partial-result storage carries no reset: every entry is written before
  // it is read within a frame.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (!col[0]) begin
        h_reg <= in_data;
      end else if (!row[0]) begin
        row_buf[buf_idx] <= pair;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_fire) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A new result overrides a same-cycle acceptance, so out_valid stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCEPT;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_fire && row_last && col_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Only the final window's result can be pending here.
        if (out_fire) begin
          state_next = ACCEPT;
          done_next  = 1'b1;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

endmodule

// File: tb/tb_maxpool_stage.sv
// tb/tb_maxpool_stage.sv - self-checking bench for maxpool_stage
// Build option: POOL_AVG_EN switches expected values to average pooling.
// Ports: none (top-level bench).
module tb_maxpool_stage;

  typedef logic signed [31:0] data_t;
  typedef struct {
    data_t din [36];
    data_t exp [9];
  } vec_t;

  localparam data_t SMAX = 32'sh7FFFFFFF;
  localparam data_t SMIN = 32'sh80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        frame_done;

  int    checks = 0;
  int    passes = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  data_t got_q[$];
  bit    prev_stall = 0;
  data_t prev_data = '0;

  maxpool_stage #(.DATA_W(32), .IN_W(6), .IN_H(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Reference: pool each 2x2 window directly from the whole frame.
  function automatic void pool_ref(input data_t f[36], output data_t o[9]);
    longint s;
    data_t  m;
    data_t  w[4];
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w[0] = f[(2*wr)*6 + 2*wc];
        w[1] = f[(2*wr)*6 + 2*wc + 1];
        w[2] = f[(2*wr+1)*6 + 2*wc];
        w[3] = f[(2*wr+1)*6 + 2*wc + 1];
`ifdef POOL_AVG_EN
        s = longint'(w[0]) + longint'(w[1]) + longint'(w[2]) + longint'(w[3]);
        o[wr*3+wc] = data_t'(s >>> 2);
`else
        m = w[0];
        for (int k = 1; k < 4; k++) if (w[k] > m) m = w[k];
        o[wr*3+wc] = m;
`endif
        s = 0;
      end
    end
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(data_t'(out_data)), longint'(prev_data));
      end
      if (out_valid && !out_ready) check("in_ready_stall", longint'(in_ready), 0);
      if (out_valid && out_ready) got_q.push_back(data_t'(out_data));
      if (frame_done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = data_t'(out_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Called and returns at posedge+1.
  task automatic drive_frame(input data_t f[36], input bit rnd, input int nbeats);
    int i = 0;
    int guard = 0;
    while (i < nbeats && guard < 3000) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = f[i];
      end
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check("drive_budget", longint'(i), longint'(nbeats));
  endtask

  task automatic wait_out(input int n, input int dn);
    int t = 0;
    while ((got_q.size() < n || done_cnt < dn) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("wait_budget", longint'(t < 3000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_outputs(input string nm, input data_t e[9], input int base);
    for (int k = 0; k < 9; k++) begin
      if (base + k < got_q.size())
        check(nm, longint'(got_q[base+k]), longint'(e[k]));
      else
        check({nm, "_missing"}, longint'(got_q.size()), longint'(base + k + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [4];
    data_t ramp [36];
    data_t ramp_exp [9];
    data_t rf [3][36];
    data_t rexp [9];
    data_t tmp [36];
    int    pos;

    for (int i = 0; i < 36; i++) ramp[i] = data_t'(i);
`ifdef POOL_AVG_EN
    ramp_exp = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
`else
    ramp_exp = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
`endif

    // Vector 0: ramp.
    vecs[0].din = ramp;
    vecs[0].exp = ramp_exp;
    // Vector 1: all -5, one -1 per window at a position rotating per window.
    for (int i = 0; i < 36; i++) vecs[1].din[i] = -5;
    for (int w = 0; w < 9; w++) begin
      pos = (2*(w/3) + (w%4)/2) * 6 + 2*(w%3) + (w%2);
      vecs[1].din[pos] = -1;
`ifdef POOL_AVG_EN
      vecs[1].exp[w] = -4;
`else
      vecs[1].exp[w] = -1;
`endif
    end
    // Vector 2: extremes alternating by column.
    for (int i = 0; i < 36; i++) vecs[2].din[i] = (i % 2 == 0) ? SMAX : SMIN;
    for (int w = 0; w < 9; w++) begin
`ifdef POOL_AVG_EN
      vecs[2].exp[w] = -1;
`else
      vecs[2].exp[w] = SMAX;
`endif
    end
    // Vector 3: constant -3.
    for (int i = 0; i < 36; i++) vecs[3].din[i] = -3;
    for (int w = 0; w < 9; w++) vecs[3].exp[w] = -3;

    // Reset state.
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, downstream always ready.
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      done_cnt = 0;
      drive_frame(vecs[v].din, 0, 36);
      wait_out(9, 1);
      check($sformatf("vec%0d_count", v), longint'(got_q.size()), 9);
      compare_outputs($sformatf("vec%0d_out", v), vecs[v].exp, 0);
      check($sformatf("vec%0d_done", v), longint'(done_cnt), 1);
    end

    // Backpressure: stall after the first output.
    got_q.delete();
    done_cnt = 0;
    ready_mode = 2;
    out_ready = 1'b1;
    fork
      drive_frame(ramp, 0, 36);
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("bp_in_ready", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        check("bp_taken_before_stall", longint'(got_q.size()), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_out(9, 1);
    check("bp_count", longint'(got_q.size()), 9);
    compare_outputs("bp_out", ramp_exp, 0);
    check("bp_done", longint'(done_cnt), 1);
    ready_mode = 0;

    // Random traffic over three back-to-back frames.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 36; i++) begin
        case ($urandom_range(0, 9))
          0: rf[f][i] = SMAX;
          1: rf[f][i] = SMIN;
          default: rf[f][i] = data_t'($urandom_range(0, 2000)) - 1000;
        endcase
      end
    end
    got_q.delete();
    done_cnt = 0;
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      tmp = rf[f];
      drive_frame(tmp, 1, 36);
    end
    wait_out(27, 3);
    check("rand_count", longint'(got_q.size()), 27);
    for (int f = 0; f < 3; f++) begin
      tmp = rf[f];
      pool_ref(tmp, rexp);
      compare_outputs($sformatf("rand_f%0d", f), rexp, f * 9);
    end
    check("rand_done", longint'(done_cnt), 3);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset after 20 accepted inputs; beat 20 closes a window.
    got_q.delete();
    done_cnt = 0;
    drive_frame(ramp, 0, 20);
    check("mid_out_valid_pre", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_out_valid", longint'(out_valid), 0);
    check("mid_frame_done", longint'(frame_done), 0);
    check("mid_out_data", longint'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_no_done", longint'(done_cnt), 0);
    got_q.delete();
    @(posedge clk);
    #1;
    drive_frame(ramp, 0, 36);
    wait_out(9, 1);
    check("post_rst_count", longint'(got_q.size()), 9);
    compare_outputs("post_rst_out", ramp_exp, 0);
    check("post_rst_done", longint'(done_cnt), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
